// File: rtl/mod_counter_pkg.sv
// ----------------------------------------------------------------------------
// mod_counter_pkg: shared constants, direction enum and width helper.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mod_counter_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Bits needed to hold the values 0..n-1, never less than one.
  function automatic int unsigned width_for(input longint unsigned n);
    return (n <= 64'd2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_counter_prescaler.sv
// ----------------------------------------------------------------------------
// mod_counter_prescaler: enable-gated phase counter for mod_counter.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mod_counter_prescaler
  import mod_counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int unsigned     PW   = width_for(longint'(PRESCALE));
  localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  // tick marks the last phase regardless of en so the parent can use it
  // both to gate stepping (with en) and to qualify terminal (without en).
  assign tick = (phase == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
    end else if (restart) begin
      phase <= '0;
    end else if (en) begin
      phase <= tick ? '0 : phase + PW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mod_counter.sv
// ----------------------------------------------------------------------------
// mod_counter: parametrised modulo up/down counter; optional prescaler under MOD_COUNTER_PRESCALE_EN.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int unsigned     WIDTH       = 8,
  parameter longint unsigned MODULUS     = 64'd1 << WIDTH,
  parameter longint unsigned RESET_VALUE = 0
`ifdef MOD_COUNTER_PRESCALE_EN
  ,
  parameter int unsigned     PRESCALE    = 4
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             terminal
);

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   MAX_EXT = MOD_EXT - (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MAX_VAL = MAX_EXT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

  dir_e             dir;
  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   load_ext;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   dec_ext;
  logic             wrap_up;
  logic             wrap_dn;
  logic             pre_last;
  logic             step;
  logic [WIDTH-1:0] next_count;
  logic             next_wrap;

  assign dir       = dir_e'(up);
  assign count_ext = {1'b0, count};
  assign load_ext  = {1'b0, load_value};
  assign inc_ext   = count_ext + (WIDTH+1)'(1);
  assign dec_ext   = count_ext - (WIDTH+1)'(1);

  // The extra bit lets MODULUS=2**WIDTH be compared directly and turns a
  // decrement from zero into a visible borrow.
  assign wrap_up = (inc_ext == MOD_EXT);
  assign wrap_dn = dec_ext[WIDTH];

`ifdef MOD_COUNTER_PRESCALE_EN
  logic tick;

  mod_counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .restart (clear | load),
    .tick    (tick)
  );

  assign pre_last = tick;
`else
  assign pre_last = 1'b1;
`endif

  assign step     = en & pre_last;
  assign terminal = pre_last & ((dir == DIR_UP) ? wrap_up : wrap_dn);

  always_comb begin
    next_count = count;
    next_wrap  = 1'b0;
    if (clear) begin
      next_count = '0;
    end else if (load) begin
      next_count = (load_ext >= MOD_EXT) ? MAX_VAL : load_value;
    end else if (step) begin
      if (dir == DIR_UP) begin
        next_count = wrap_up ? '0 : inc_ext[WIDTH-1:0];
        next_wrap  = wrap_up;
      end else begin
        next_count = wrap_dn ? MAX_VAL : dec_ext[WIDTH-1:0];
        next_wrap  = wrap_dn;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= RST_VAL;
      wrap  <= 1'b0;
    end else begin
      count <= next_count;
      wrap  <= next_wrap;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mod_counter.sv
// ----------------------------------------------------------------------------
// tb_mod_counter: four counter configurations on shared stimulus against a behavioural model.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mod_counter;

  logic       clk, reset, en, up, clear, load;
  logic [7:0] load_value;
  logic [7:0] cnt_a, cnt_b, cnt_c;
  logic       cnt_d;
  logic       wrap_a, wrap_b, wrap_c, wrap_d;
  logic       term_a, term_b, term_c, term_d;

  int n_vec = 0;
  int n_err = 0;

  // Instance configurations: a=default 8-bit, b=mod 10 reset 3, c=mod 100, d=1-bit.
  int unsigned mm[4]    = '{256, 10, 100, 2};
  int unsigned mrv[4]   = '{0, 3, 0, 0};
  int unsigned mmask[4] = '{255, 255, 255, 1};
  int unsigned mc[4];
  bit          mw[4];
`ifdef MOD_COUNTER_PRESCALE_EN
  localparam int unsigned P = 4;
  int unsigned pc;
`endif

  typedef struct packed {
    logic [3:0][7:0] c;
    logic [3:0]      w;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        e, u, c, l;
    logic [7:0]  v;
    int unsigned eb;
    logic        wb;
    int unsigned ec;
    logic        wc;
  } vec_t;

  mod_counter u_a (
    .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
    .load_value(load_value), .count(cnt_a), .wrap(wrap_a), .terminal(term_a));
  mod_counter #(.WIDTH(8), .MODULUS(10), .RESET_VALUE(3)) u_b (
    .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
    .load_value(load_value), .count(cnt_b), .wrap(wrap_b), .terminal(term_b));
  mod_counter #(.WIDTH(8), .MODULUS(100)) u_c (
    .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
    .load_value(load_value), .count(cnt_c), .wrap(wrap_c), .terminal(term_c));
  mod_counter #(.WIDTH(1)) u_d (
    .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
    .load_value(load_value[0]), .count(cnt_d), .wrap(wrap_d), .terminal(term_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] act_cnt(input int i);
    case (i)
      0:       return {24'b0, cnt_a};
      1:       return {24'b0, cnt_b};
      2:       return {24'b0, cnt_c};
      default: return {31'b0, cnt_d};
    endcase
  endfunction

  function automatic logic [31:0] act_wrap(input int i);
    case (i)
      0:       return {31'b0, wrap_a};
      1:       return {31'b0, wrap_b};
      2:       return {31'b0, wrap_c};
      default: return {31'b0, wrap_d};
    endcase
  endfunction

  function automatic logic [31:0] act_term(input int i);
    case (i)
      0:       return {31'b0, term_a};
      1:       return {31'b0, term_b};
      2:       return {31'b0, term_c};
      default: return {31'b0, term_d};
    endcase
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d at %0t: got %0d, expected %0d", name, i, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mc[i] = mrv[i];
      mw[i] = 1'b0;
    end
`ifdef MOD_COUNTER_PRESCALE_EN
    pc = 0;
`endif
  endtask

  function automatic logic [31:0] m_term(input int i, input logic u);
    bit t;
    t = u ? (mc[i] == mm[i] - 1) : (mc[i] == 0);
`ifdef MOD_COUNTER_PRESCALE_EN
    t = t && (pc == P - 1);
`endif
    return {31'b0, t};
  endfunction

  task automatic model_step(input logic e, u, c, l, input logic [7:0] v);
    bit          st;
    int unsigned lv;
    st = e;
`ifdef MOD_COUNTER_PRESCALE_EN
    st = 1'b0;
    if (c || l) pc = 0;
    else if (e) begin
      if (pc == P - 1) begin
        pc = 0;
        st = 1'b1;
      end else pc = pc + 1;
    end
`endif
    for (int i = 0; i < 4; i++) begin
      lv    = int'(v) & mmask[i];
      mw[i] = 1'b0;
      if (c) mc[i] = 0;
      else if (l) mc[i] = (lv >= mm[i]) ? mm[i] - 1 : lv;
      else if (st) begin
        if (u) begin
          mw[i] = (mc[i] == mm[i] - 1);
          mc[i] = (mc[i] + 1) % mm[i];
        end else begin
          mw[i] = (mc[i] == 0);
          mc[i] = (mc[i] + mm[i] - 1) % mm[i];
        end
      end
    end
  endtask

  // Called at posedge+1: drive, check terminal, queue the prediction, then
  // compare it after the following edge.
  task automatic cycle(input logic e, u, c, l, input logic [7:0] v);
    exp_t x;
    en = e; up = u; clear = c; load = l; load_value = v;
    #1;
    for (int i = 0; i < 4; i++) chk("terminal", i, act_term(i), m_term(i, u));
    model_step(e, u, c, l, v);
    for (int i = 0; i < 4; i++) begin
      x.c[i] = 8'(mc[i]);
      x.w[i] = mw[i];
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      chk("count", i, act_cnt(i), {24'b0, x.c[i]});
      chk("wrap", i, act_wrap(i), {31'b0, x.w[i]});
    end
  endtask

  initial begin
    vec_t tbl[14];
    int   guard;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   2, 1'b0, 99, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   1, 1'b0, 98, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   0, 1'b0, 97, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   9, 1'b1, 96, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8, 1'b0, 95, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd200, 9, 1'b0, 99, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   0, 1'b1, 0,  1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   1, 1'b0, 1,  1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd50,  9, 1'b0, 50, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'd77,  0, 1'b0, 0,  1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd77,  9, 1'b0, 77, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd5,   5, 1'b0, 5,  1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   5, 1'b0, 5,  1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   0, 1'b0, 0,  1'b0};

    reset = 1'b1; en = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; load_value = 8'd0;
    model_reset();
    #6;
    chk("reset_count", 0, act_cnt(0), 32'd0);
    chk("reset_count", 1, act_cnt(1), 32'd3);
    chk("reset_wrap", 1, act_wrap(1), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

`ifndef MOD_COUNTER_PRESCALE_EN
    for (int k = 0; k < 14; k++) begin
      cycle(tbl[k].e, tbl[k].u, tbl[k].c, tbl[k].l, tbl[k].v);
      chk("tbl_count_b", k, act_cnt(1), tbl[k].eb);
      chk("tbl_wrap_b", k, act_wrap(1), {31'b0, tbl[k].wb});
      chk("tbl_count_c", k, act_cnt(2), tbl[k].ec);
      chk("tbl_wrap_c", k, act_wrap(2), {31'b0, tbl[k].wc});
    end
`else
    begin
      logic [8:0] pen;
      int         pexp[9];
      pen  = 9'b1_1111_1011;
      pexp = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
      for (int k = 0; k < 9; k++) begin
        cycle(pen[k], 1'b1, 1'b0, 1'b0, 8'd0);
        chk("pre_count_a", k, act_cnt(0), pexp[k]);
      end
      for (int k = 0; k < 14; k++)
        cycle(tbl[k].e, tbl[k].u, tbl[k].c, tbl[k].l, tbl[k].v);
    end
`endif

    // Count up to 7, then hit reset between clock edges.
    guard = 0;
    while (mc[0] != 7 && guard < 2000) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
      guard++;
    end
    chk("reach_seven", 0, act_cnt(0), 32'd7);
    #2;
    reset = 1'b1;
    en    = 1'b0;
    model_reset();
    #1;
    chk("async_count", 0, act_cnt(0), 32'd0);
    chk("async_count", 1, act_cnt(1), 32'd3);
    for (int i = 0; i < 4; i++) chk("async_wrap", i, act_wrap(i), 32'd0);
    for (int i = 0; i < 4; i++) chk("async_term", i, act_term(i), m_term(i, up));
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    chk("hold_after_release", 0, act_cnt(0), 32'd0);

    for (int k = 0; k < 260; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
`ifndef MOD_COUNTER_PRESCALE_EN
      if (k == 255) begin
        chk("run_wrap_count", 0, act_cnt(0), 32'd0);
        chk("run_wrap_flag", 0, act_wrap(0), 32'd1);
      end
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
